sysid_checker: RTL and testbench

Boot-time integrity checker that sits directly downstream of the `nios_system` system-ID slave. It acts as an Avalon-MM read master on that slave's control port and reads word 0 (system ID) and word 1 (generation timestamp). It compares both words against build-time parameters. Its pass/fail flags gate enabling of the edge-detection streaming pipeline, so a mismatched FPGA image never processes frames.

---
 rtl/sysid_checker_pkg.sv | 23 ++
 rtl/sysid_read_port.sv | 102 ++++++++++
 rtl/sysid_checker.sv | 142 ++++++++++++++
 tb/tb_sysid_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared definitions for the boot-time system-ID checker: FSM encodings and
// the sysid slave word addresses.
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WAIT_ID,
        RD_TS,
        WAIT_TS,
        DONE
    } sysid_state_e;

    typedef enum logic [1:0] {
        RP_IDLE,
        RP_REQ,
        RP_WAIT
    } rp_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_read_port.sv
// One Avalon-MM read transaction: waitrequest handling, fixed read latency
// and a per-read timeout.
module sysid_read_port
    import sysid_checker_pkg::*;
#(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic        address,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        rd_accept,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_timeout
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]       LAT_INIT = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    rp_state_e        state, state_nxt;
    logic [CNT_W-1:0] to_cnt;
    logic [1:0]       lat_cnt;
    logic             addr_q;
    logic             tc;

    assign tc          = (to_cnt == CNT_TC);
    assign avm_address = addr_q;
    assign rd_data     = avm_readdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RP_IDLE;
            to_cnt  <= '0;
            lat_cnt <= '0;
            addr_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (go) begin
                to_cnt <= '0;
                addr_q <= address;
            end else if (state != RP_IDLE && !tc) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (rd_accept) begin
                lat_cnt <= LAT_INIT;
            end else if (state == RP_WAIT && lat_cnt != 2'd0) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
        end
    end

    // Reaching the timeout count withdraws the read in that same cycle, so a
    // stalled read is held for exactly TIMEOUT_CYCLES cycles.
    always_comb begin
        state_nxt  = state;
        avm_read   = 1'b0;
        rd_accept  = 1'b0;
        rd_valid   = 1'b0;
        rd_timeout = 1'b0;
        case (state)
            RP_IDLE: begin
                if (go) state_nxt = RP_REQ;
            end
            RP_REQ: begin
                if (tc) begin
                    rd_timeout = 1'b1;
                    state_nxt  = RP_IDLE;
                end else begin
                    avm_read = 1'b1;
                    if (!avm_waitrequest) begin
                        rd_accept = 1'b1;
                        if (READ_LATENCY == 0) begin
                            rd_valid  = 1'b1;
                            state_nxt = RP_IDLE;
                        end else begin
                            state_nxt = RP_WAIT;
                        end
                    end
                end
            end
            RP_WAIT: begin
                if (tc) begin
                    rd_timeout = 1'b1;
                    state_nxt  = RP_IDLE;
                end else if (lat_cnt == 2'd0) begin
                    rd_valid  = 1'b1;
                    state_nxt = RP_IDLE;
                end
            end
            default: state_nxt = RP_IDLE;
        endcase
        if (go) state_nxt = RP_REQ;
    end

endmodule

// File: rtl/sysid_checker.sv
// Boot-time image check: reads sysid words 0 and 1 and compares them with the
// build-time ID and timestamp, gating the streaming pipeline enable.
//
//   state   | meaning
//   IDLE    | waiting for start or the post-reset auto check
//   RD_ID   | read of word 0 issued / stalled
//   WAIT_ID | counting read latency for word 0
//   RD_TS   | read of word 1 issued / stalled
//   WAIT_TS | counting read latency for word 1
//   DONE    | one-cycle done pulse, results valid
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h63D6_F610,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    sysid_state_e state, state_nxt;
    logic         auto_pend;
    logic         go, go_addr;
    logic         clear, cap_id, cap_ts, set_to;
    logic         rd_accept, rd_valid, rd_timeout;
    logic [31:0]  rd_data;

    sysid_read_port #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_read_port (
        .clock           (clock),
        .reset           (reset),
        .go              (go),
        .address         (go_addr),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .rd_accept       (rd_accept),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .rd_timeout      (rd_timeout)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign pass = id_ok & ts_ok & ~timeout;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            auto_pend <= AUTO_START;
        end else begin
            state <= state_nxt;
            if (clear) auto_pend <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            if (cap_id) begin
                id_value <= rd_data;
                id_ok    <= (rd_data == EXPECTED_ID);
            end
            if (cap_ts) begin
                ts_value <= rd_data;
                ts_ok    <= (rd_data == EXPECTED_TS);
            end
            if (set_to) timeout <= 1'b1;
        end
    end

    // The TS read is launched in the same cycle the ID word is captured.
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        go_addr   = SYSID_ADDR_ID;
        clear     = 1'b0;
        cap_id    = 1'b0;
        cap_ts    = 1'b0;
        set_to    = 1'b0;
        case (state)
            IDLE: begin
                if (start || auto_pend) begin
                    clear     = 1'b1;
                    go        = 1'b1;
                    state_nxt = RD_ID;
                end
            end
            RD_ID, WAIT_ID: begin
                if (rd_timeout) begin
                    set_to    = 1'b1;
                    state_nxt = DONE;
                end else if (rd_valid) begin
                    cap_id    = 1'b1;
                    go        = 1'b1;
                    go_addr   = SYSID_ADDR_TS;
                    state_nxt = RD_TS;
                end else if (rd_accept) begin
                    state_nxt = WAIT_ID;
                end
            end
            RD_TS, WAIT_TS: begin
                if (rd_timeout) begin
                    set_to    = 1'b1;
                    state_nxt = DONE;
                end else if (rd_valid) begin
                    cap_ts    = 1'b1;
                    state_nxt = DONE;
                end else if (rd_accept) begin
                    state_nxt = WAIT_TS;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: default zero-wait instance, a stalled
// latency-2 instance and a timeout instance.
module tb_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'h63D6_F610;
    localparam logic [31:0] TS_BAD  = 32'h63D6_F611;
    localparam logic [31:0] ID_B    = 32'hA5A5_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // instance a: defaults, zero-wait slave
    logic        reset_a, start_a, addr_a, read_a, busy_a, done_a;
    logic        id_ok_a, ts_ok_a, pass_a, to_a;
    logic [31:0] rdata_a, idv_a, tsv_a, id_ret_a, ts_ret_a;
    assign rdata_a = addr_a ? ts_ret_a : id_ret_a;

    sysid_checker u_a (
        .clock(clk), .reset(reset_a), .start(start_a),
        .avm_address(addr_a), .avm_read(read_a), .avm_readdata(rdata_a),
        .avm_waitrequest(1'b0), .busy(busy_a), .done(done_a),
        .id_ok(id_ok_a), .ts_ok(ts_ok_a), .pass(pass_a), .timeout(to_a),
        .id_value(idv_a), .ts_value(tsv_a)
    );

    // instance b: READ_LATENCY=2, five stall cycles per read
    logic        reset_b, start_b, addr_b, read_b, wr_b, busy_b, done_b;
    logic        id_ok_b, ts_ok_b, pass_b, to_b;
    logic [31:0] rdata_b, idv_b, tsv_b;
    logic        last_addr_b = 1'b0;
    int          stall_b = 0;
    assign wr_b    = read_b && (stall_b < 5);
    assign rdata_b = last_addr_b ? TS_GOOD : ID_B;

    sysid_checker #(.EXPECTED_ID(ID_B), .READ_LATENCY(2), .AUTO_START(1'b0)) u_b (
        .clock(clk), .reset(reset_b), .start(start_b),
        .avm_address(addr_b), .avm_read(read_b), .avm_readdata(rdata_b),
        .avm_waitrequest(wr_b), .busy(busy_b), .done(done_b),
        .id_ok(id_ok_b), .ts_ok(ts_ok_b), .pass(pass_b), .timeout(to_b),
        .id_value(idv_b), .ts_value(tsv_b)
    );

    // instance c: TIMEOUT_CYCLES=8, waitrequest stuck high
    logic        reset_c, start_c, addr_c, read_c, busy_c, done_c;
    logic        id_ok_c, ts_ok_c, pass_c, to_c;
    logic [31:0] idv_c, tsv_c;

    sysid_checker #(.TIMEOUT_CYCLES(8), .AUTO_START(1'b0)) u_c (
        .clock(clk), .reset(reset_c), .start(start_c),
        .avm_address(addr_c), .avm_read(read_c), .avm_readdata(32'h0),
        .avm_waitrequest(1'b1), .busy(busy_c), .done(done_c),
        .id_ok(id_ok_c), .ts_ok(ts_ok_c), .pass(pass_c), .timeout(to_c),
        .id_value(idv_c), .ts_value(tsv_c)
    );

    // slave model for b plus protocol monitors
    logic prev_stall_b = 1'b0, prev_addr_b = 1'b0;
    int   addr_viol_b = 0, stalls_seen_b = 0, ts_issued_c = 0, done_cnt_a = 0;

    always @(posedge clk) begin
        if (reset_b) begin
            stall_b <= 0;
        end else if (read_b) begin
            stall_b <= wr_b ? stall_b + 1 : 0;
            if (!wr_b) last_addr_b <= addr_b;
        end
        if (prev_stall_b && (!read_b || addr_b !== prev_addr_b)) addr_viol_b <= addr_viol_b + 1;
        if (read_b && wr_b) stalls_seen_b <= stalls_seen_b + 1;
        prev_stall_b <= read_b && wr_b;
        prev_addr_b  <= addr_b;
        if (read_c && addr_c) ts_issued_c <= ts_issued_c + 1;
    end

    always @(negedge clk) if (done_a) done_cnt_a <= done_cnt_a + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // returns cycles until done (1 = next cycle), or -1 if the budget expires
    task automatic wait_done(input int sel, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            logic d;
            tick();
            case (sel)
                0:       d = done_a;
                1:       d = done_b;
                default: d = done_c;
            endcase
            if (d) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat, dc;

    initial begin
        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        id_ret_a = 32'h0; ts_ret_a = TS_GOOD;
        repeat (3) tick();

        check("rst_busy",   {31'b0, busy_a}, 32'd0);
        check("rst_done",   {31'b0, done_a}, 32'd0);
        check("rst_read",   {31'b0, read_a}, 32'd0);
        check("rst_pass",   {31'b0, pass_a}, 32'd0);
        check("rst_to",     {31'b0, to_a},   32'd0);
        check("rst_id_val", idv_a,           32'd0);
        check("rst_ts_val", tsv_a,           32'd0);

        // auto start after reset release
        reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
        wait_done(0, 20, lat);
        check("auto_lat",  lat,              32'd3);
        check("auto_pass", {31'b0, pass_a}, 32'd1);
        check("b_no_auto", {31'b0, busy_b}, 32'd0);
        check("c_no_auto", {31'b0, busy_c}, 32'd0);
        tick();

        // zero-wait directed check, cycle by cycle
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        check("c1_read", {31'b0, read_a}, 32'd1);
        check("c1_addr", {31'b0, addr_a}, 32'd0);
        tick();
        check("c2_read", {31'b0, read_a}, 32'd1);
        check("c2_addr", {31'b0, addr_a}, 32'd1);
        tick();
        check("c3_done",  {31'b0, done_a},  32'd1);
        check("c3_busy",  {31'b0, busy_a},  32'd1);
        check("c3_pass",  {31'b0, pass_a},  32'd1);
        check("c3_id_ok", {31'b0, id_ok_a}, 32'd1);
        check("c3_ts_ok", {31'b0, ts_ok_a}, 32'd1);
        check("c3_id_val", idv_a, 32'h0);
        check("c3_ts_val", tsv_a, TS_GOOD);
        tick();
        check("c4_busy", {31'b0, busy_a}, 32'd0);
        check("c4_done", {31'b0, done_a}, 32'd0);

        // timestamp mismatch; results clear on start
        ts_ret_a = TS_BAD;
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        check("clr_id_ok",  {31'b0, id_ok_a}, 32'd0);
        check("clr_ts_val", tsv_a,            32'd0);
        wait_done(0, 20, lat);
        check("bad_lat",   lat + 1,           32'd3);
        check("bad_id_ok", {31'b0, id_ok_a}, 32'd1);
        check("bad_ts_ok", {31'b0, ts_ok_a}, 32'd0);
        check("bad_pass",  {31'b0, pass_a},  32'd0);
        check("bad_to",    {31'b0, to_a},    32'd0);
        check("bad_ts_val", tsv_a,           TS_BAD);
        ts_ret_a = TS_GOOD;
        tick();

        // start re-pulsed during RD_ID is ignored and not queued
        dc = done_cnt_a;
        start_a = 1'b1;
        tick();
        tick(); start_a = 1'b0;
        wait_done(0, 20, lat);
        check("ign_lat", lat + 2, 32'd3);
        tick();
        check("ign_idle",  {31'b0, busy_a},     32'd0);
        check("ign_ndone", done_cnt_a - dc,     32'd1);
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        check("b2b_busy", {31'b0, busy_a}, 32'd1);
        check("b2b_read", {31'b0, read_a}, 32'd1);
        wait_done(0, 20, lat);
        check("b2b_lat",  lat + 1,           32'd3);
        check("b2b_pass", {31'b0, pass_a},  32'd1);
        tick();

        // reset during RD_TS, then auto re-run
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        tick();
        check("rts_addr", {31'b0, addr_a}, 32'd1);
        check("rts_read", {31'b0, read_a}, 32'd1);
        reset_a = 1'b1;
        tick();
        check("rst_mid_read",  {31'b0, read_a},  32'd0);
        check("rst_mid_done",  {31'b0, done_a},  32'd0);
        check("rst_mid_busy",  {31'b0, busy_a},  32'd0);
        check("rst_mid_id_ok", {31'b0, id_ok_a}, 32'd0);
        reset_a = 1'b0;
        dc = done_cnt_a;
        wait_done(0, 20, lat);
        check("rearm_lat",  lat,              32'd3);
        check("rearm_pass", {31'b0, pass_a}, 32'd1);
        tick();
        check("rearm_ndone", done_cnt_a - dc, 32'd1);

        // stalled reads with read latency 2
        start_b = 1'b1;
        tick(); start_b = 1'b0;
        wait_done(1, 60, lat);
        check("b_lat",     lat + 1,           32'd17);
        check("b_pass",    {31'b0, pass_b},  32'd1);
        check("b_id_val",  idv_b,             ID_B);
        check("b_ts_val",  tsv_b,             TS_GOOD);
        check("b_addr_stable", addr_viol_b,   32'd0);
        check("b_stalls",  stalls_seen_b,     32'd10);

        // stuck waitrequest -> timeout on the ID read
        start_c = 1'b1;
        tick(); start_c = 1'b0;
        wait_done(2, 40, lat);
        check("c_lat",     lat + 1,           32'd10);
        check("c_timeout", {31'b0, to_c},    32'd1);
        check("c_pass",    {31'b0, pass_c},  32'd0);
        check("c_ts_ok",   {31'b0, ts_ok_c}, 32'd0);
        check("c_id_ok",   {31'b0, id_ok_c}, 32'd0);
        tick();
        check("c_no_ts_read", ts_issued_c,    32'd0);
        check("c_idle",    {31'b0, busy_c},  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
